// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: direction encoding and the
// round-robin pointer advance.
package shift_pkg;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Index that follows idx in a ring of nreq requesters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nreq);
        return (idx + 1 >= nreq) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Logarithmic logical barrel shifter: one stage per amount bit, zero fill,
// shifted-out bits discarded.
module barrel_shifter
    import shift_pkg::*;
#(
    parameter int N = 8,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  data,
    input  logic [SW-1:0] amt,
    input  logic          dir,
    output logic [N-1:0]  result
);

    logic [N-1:0] stage;

    // Stage s shifts by 2**s when amount bit s is set.
    always_comb begin
        stage = data;
        for (int s = 0; s < SW; s++) begin
            if (amt[s]) begin
                stage = (dir == DIR_RIGHT) ? (stage >> (1 << s)) : (stage << (1 << s));
            end
        end
        result = stage;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: search begins at pointer and wraps; the first requester
// found wins. grant is one-hot, or zero when nobody requests.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  pointer,
    output logic [NREQ-1:0] grant
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           found;

    // Walk the ring from the pointer, grant the first active request.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, pointer} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one barrel shifter between NREQ requesters with round-robin
// arbitration and a single registered result slot.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready is one-hot to the round-robin winner, asserted only
// when the result slot is empty or being drained this cycle (out_ready),
// and is zero during reset. Requesters hold their command while valid and
// not ready. The consumer takes a result when out_valid && out_ready; the
// slot holds steady otherwise.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int CNTW = 16,
    localparam int SW  = $clog2(N),
    localparam int IDW = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*N-1:0]  req_data,
    input  logic [NREQ*SW-1:0] req_amt,
    input  logic [NREQ-1:0]    req_dir,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_data,
    output logic [IDW-1:0]     out_id,
    output logic [CNTW-1:0]    txn_count
);

    logic [IDW-1:0]  pointer;
    logic [NREQ-1:0] grant;
    logic            slot_free;
    logic            accept;
    logic [IDW-1:0]  win_id;
    logic [N-1:0]    win_data;
    logic [SW-1:0]   win_amt;
    logic            win_dir;
    logic [N-1:0]    shifted;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .pointer (pointer),
        .grant   (grant)
    );

    assign slot_free = !out_valid || out_ready;
    assign req_ready = (rst_n && slot_free) ? grant : '0;
    assign accept    = |req_ready;

    // Route the winner's command to the shared shifter.
    always_comb begin
        win_id   = '0;
        win_data = '0;
        win_amt  = '0;
        win_dir  = DIR_LEFT;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_id   = IDW'(i);
                win_data = req_data[i*N +: N];
                win_amt  = req_amt[i*SW +: SW];
                win_dir  = req_dir[i];
            end
        end
    end

    barrel_shifter #(.N(N)) u_shift (
        .data   (win_data),
        .amt    (win_amt),
        .dir    (win_dir),
        .result (shifted)
    );

    // Result slot, priority pointer and transaction counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            pointer   <= '0;
            txn_count <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= shifted;
            out_id    <= win_id;
            pointer   <= IDW'(rr_next(32'(win_id), NREQ));
            txn_count <= txn_count + CNTW'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;
    localparam int N      = 8;
    localparam int NREQ   = 4;
    localparam int SW     = 3;
    localparam int IDW    = 2;
    localparam int CNTW_S = 4;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [NREQ-1:0]     req_valid, req_dir, req_ready, req_ready_w;
    logic [N-1:0]        d_in [NREQ];
    logic [SW-1:0]       a_in [NREQ];
    logic [NREQ*N-1:0]   req_data;
    logic [NREQ*SW-1:0]  req_amt;
    logic                out_ready;
    logic                out_valid, out_valid_w;
    logic [N-1:0]        out_data, out_data_w;
    logic [IDW-1:0]      out_id, out_id_w;
    logic [15:0]         txn_count;
    logic [CNTW_S-1:0]   txn_count_w;

    always_comb begin
        req_data = '0;
        req_amt  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*N +: N]   = d_in[i];
            req_amt[i*SW +: SW]  = a_in[i];
        end
    end

    shift_arbiter #(.N(N), .NREQ(NREQ), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_amt(req_amt), .req_dir(req_dir),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .txn_count(txn_count)
    );

    shift_arbiter #(.N(N), .NREQ(NREQ), .CNTW(CNTW_S)) dut_w (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_w),
        .req_data(req_data), .req_amt(req_amt), .req_dir(req_dir),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .out_id(out_id_w), .txn_count(txn_count_w)
    );

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int failures = 0;

    logic [IDW+N-1:0] exp_q[$];   // results sitting in the slot
    int               m_ptr, m_cnt, m_id;
    logic [N-1:0]     m_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Shift computed as multiplication / division by a power of two.
    function automatic logic [N-1:0] ref_shift(input int data, input int amt, input bit dir);
        int p;
        p = 1 << amt;
        if (dir) return N'(data / p);
        return N'((data * p) % (1 << N));
    endfunction

    function automatic int model_winner();
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] model_ready();
        int w;
        w = model_winner();
        if (!rst_n || w < 0) return '0;
        if (exp_q.size() != 0 && !out_ready) return '0;
        return NREQ'(1) << w;
    endfunction

    task automatic model_edge();
        int w;
        bit free;
        logic [N-1:0] r;
        if (!rst_n) begin
            exp_q.delete();
            m_data = '0; m_id = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            w    = model_winner();
            free = (exp_q.size() == 0) || out_ready;
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            if (w >= 0 && free) begin
                r = ref_shift(int'(d_in[w]), int'(a_in[w]), req_dir[w]);
                exp_q.push_back({IDW'(w), r});
                m_data = r; m_id = w; m_ptr = (w + 1) % NREQ; m_cnt++;
            end
        end
    endtask

    // One clock: check handshake before the edge, outputs after it.
    task automatic cycle();
        #1;
        check("req_ready", 32'(req_ready), 32'(model_ready()));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_id", 32'(out_id), 32'(m_id));
        check("txn_count", 32'(txn_count), 32'(m_cnt % 65536));
        check("txn_count_w", 32'(txn_count_w), 32'(m_cnt % 16));
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_req();
        req_valid = '0;
        req_dir   = '0;
        for (int i = 0; i < NREQ; i++) begin
            d_in[i] = '0;
            a_in[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    typedef struct {
        int           r;
        logic [N-1:0] d;
        int           amt;
        bit           dir;
        logic [N-1:0] exp;
    } vec_t;

    vec_t vecs [8];
    int   rr_exp [5];

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{2, 8'hB3, 3, 1'b0, 8'h98};
        vecs[1] = '{1, 8'hF0, 4, 1'b1, 8'h0F};
        vecs[2] = '{0, 8'h5A, 0, 1'b0, 8'h5A};
        vecs[3] = '{3, 8'h5A, 0, 1'b1, 8'h5A};
        vecs[4] = '{1, 8'h01, 7, 1'b0, 8'h80};
        vecs[5] = '{2, 8'h80, 7, 1'b1, 8'h01};
        vecs[6] = '{0, 8'hFF, 7, 1'b0, 8'h80};
        vecs[7] = '{3, 8'hFF, 7, 1'b1, 8'h01};
        rr_exp  = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        out_ready = 1'b1;
        clear_req();
        @(negedge clk);

        // Reset held for two cycles, then idle.
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        check("idle_valid", 32'(out_valid), 0);
        check("idle_ready", 32'(req_ready), 0);
        check("idle_cnt", 32'(txn_count), 0);

        // Table of single-requester shifts, including the boundaries.
        for (int v = 0; v < 8; v++) begin
            clear_req();
            req_valid[vecs[v].r] = 1'b1;
            d_in[vecs[v].r]      = vecs[v].d;
            a_in[vecs[v].r]      = SW'(vecs[v].amt);
            req_dir[vecs[v].r]   = vecs[v].dir;
            cycle();
            check("vec_valid", 32'(out_valid), 1);
            check("vec_data", 32'(out_data), 32'(vecs[v].exp));
            check("vec_id", 32'(out_id), 32'(vecs[v].r));
            if (v == 0) check("single_cnt", 32'(txn_count), 1);
        end
        clear_req();
        cycle();
        check("drain_valid", 32'(out_valid), 0);

        // Round-robin with everyone requesting.
        do_reset();
        clear_req();
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) d_in[i] = N'(8'h11 * (i + 1));
        d_in[1] = 8'hF0; a_in[1] = 3'd4; req_dir[1] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cycle();
            check("rr_id", 32'(out_id), 32'(rr_exp[j]));
            if (rr_exp[j] == 1) check("rr_right", 32'(out_data), 32'(8'h0F));
        end

        // Backpressure with requesters 0 and 3 waiting.
        req_valid = 4'b1001;
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            cycle();
            check("bp_ready", 32'(req_ready), 0);
            check("bp_valid", 32'(out_valid), 1);
            check("bp_id", 32'(out_id), 0);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_drain1_valid", 32'(out_valid), 1);
        check("bp_drain1_id", 32'(out_id), 3);
        cycle();
        check("bp_drain2_valid", 32'(out_valid), 1);
        check("bp_drain2_id", 32'(out_id), 0);
        clear_req();
        cycle();
        check("bp_empty", 32'(out_valid), 0);

        // Counter wrap on the narrow instance.
        do_reset();
        req_valid = '1;
        for (int j = 0; j < 17; j++) cycle();
        check("wrap_narrow", 32'(txn_count_w), 1);
        check("wrap_wide", 32'(txn_count), 17);

        // Reset while a result is held; pointer must return to 0.
        rst_n = 1'b0;
        cycle();
        check("midrst_valid", 32'(out_valid), 0);
        rst_n = 1'b1;
        cycle();
        check("midrst_id", 32'(out_id), 0);

        // Randomized traffic against the model.
        for (int j = 0; j < 400; j++) begin
            req_valid = NREQ'($urandom_range(0, 15));
            req_dir   = NREQ'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                d_in[i] = N'($urandom_range(0, 255));
                a_in[i] = SW'($urandom_range(0, 7));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 63) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
